// File: rtl/adder_tree_acc_pkg.sv
// Shared types and width helpers for the adder tree
// and accumulator blocks.
package adder_pkg;

  localparam int DEF_BITWIDTH = 8;

  typedef enum logic {
    ACC_LOAD = 1'b0,
    ACC_ADD  = 1'b1
  } acc_mode_e;

  function automatic int sum_width(
    input int bitwidth,
    input int num_in
  );
    return bitwidth + $clog2(num_in);
  endfunction

endpackage

// File: rtl/adder_tree_acc_if.sv
// Beat interface of the adder tree accumulator:
// operands and controls in, accumulator and flags out.
interface adder_tree_acc_if
  import adder_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int NUM_IN   = 4,
  parameter int OWIDTH   = 12
);

  logic                       iEn;
  logic                       iClr;
  logic                       iValid;
  logic                       iAccMode;
  logic [NUM_IN*BITWIDTH-1:0] iData;
  logic                       oValid;
  logic [OWIDTH-1:0]          oData;
  logic                       oOvf;

  modport master (
    output iEn, iClr, iValid, iAccMode, iData,
    input  oValid, oData, oOvf
  );

  modport slave (
    input  iEn, iClr, iValid, iAccMode, iData,
    output oValid, oData, oOvf
  );

endinterface

// File: rtl/adder_pair_reg.sv
// One registered two-input node of the adder tree,
// carrying the beat's valid and mode alongside the sum.
module adder_pair_reg
  import adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic      iClk,
  input  logic      iRstN,
  input  logic      iEn,
  input  logic      iClr,
  input  logic [W-1:0] iA,
  input  logic [W-1:0] iB,
  input  logic      iValid,
  input  acc_mode_e iMode,
  output logic [W:0]   oSum,
  output logic      oValid,
  output acc_mode_e oMode
);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oSum   <= '0;
      oValid <= 1'b0;
      oMode  <= ACC_LOAD;
    end else if (iClr) begin
      oSum   <= '0;
      oValid <= 1'b0;
      oMode  <= ACC_LOAD;
    end else if (iEn) begin
      oSum   <= {1'b0, iA} + {1'b0, iB};
      oValid <= iValid;
      oMode  <= iMode;
    end
  end

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined binary adder tree feeding a load/accumulate
// output register with wrap or saturate overflow.
module adder_tree_acc
  import adder_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int NUM_IN   = 4,
  parameter int OWIDTH   = 12,
  parameter bit ACC_SAT  = 1'b0
) (
  input logic iClk,
  input logic iRstN,
  adder_tree_acc_if.slave bus
);

  localparam int LEVELS = $clog2(NUM_IN);
  localparam int SW     = sum_width(BITWIDTH, NUM_IN);
  localparam logic [OWIDTH-1:0] MAXV = '1;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int W  = BITWIDTH + l;
    localparam int NP = NUM_IN >> (l + 1);

    logic [W:0]    w_sum [NP];
    logic [NP-1:0] w_vld;
    logic [NP-1:0] w_mode;

    for (genvar p = 0; p < NP; p++) begin : g_pair
      logic [W-1:0] w_a;
      logic [W-1:0] w_b;
      logic         w_vi;
      acc_mode_e    w_mi;

      if (l == 0) begin : g_in
        assign w_a  = bus.iData[(2*p)*BITWIDTH +: BITWIDTH];
        assign w_b  = bus.iData[(2*p+1)*BITWIDTH +: BITWIDTH];
        assign w_vi = bus.iValid;
        assign w_mi = acc_mode_e'(bus.iAccMode);
      end else begin : g_mid
        // sibling nodes carry identical control bits
        assign w_a  = g_lvl[l-1].w_sum[2*p];
        assign w_b  = g_lvl[l-1].w_sum[2*p+1];
        assign w_vi = g_lvl[l-1].w_vld[2*p]
                    & g_lvl[l-1].w_vld[2*p+1];
        assign w_mi = acc_mode_e'(g_lvl[l-1].w_mode[2*p]
                    & g_lvl[l-1].w_mode[2*p+1]);
      end

      adder_pair_reg #(.W(W)) u_pair (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iEn    (bus.iEn),
        .iClr   (bus.iClr),
        .iA     (w_a),
        .iB     (w_b),
        .iValid (w_vi),
        .iMode  (w_mi),
        .oSum   (w_sum[p]),
        .oValid (w_vld[p]),
        .oMode  (w_mode[p])
      );
    end
  end

  logic [SW-1:0]     w_tree;
  logic              w_tvld;
  acc_mode_e         w_tmode;
  logic [OWIDTH:0]   w_ext;
  logic [OWIDTH:0]   w_add;
  logic [OWIDTH-1:0] r_data;
  logic              r_vld;
  logic              r_ovf;

  assign w_tree  = g_lvl[LEVELS-1].w_sum[0];
  assign w_tvld  = g_lvl[LEVELS-1].w_vld[0];
  assign w_tmode = acc_mode_e'(g_lvl[LEVELS-1].w_mode[0]);
  assign w_ext   = (OWIDTH+1)'(w_tree);
  assign w_add   = {1'b0, r_data} + w_ext;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.iClr) begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.iEn) begin
      r_vld <= w_tvld;
      if (w_tvld) begin
        if (w_tmode == ACC_ADD) begin
          if (w_add[OWIDTH]) begin
            r_ovf  <= 1'b1;
            r_data <= ACC_SAT ? MAXV : w_add[OWIDTH-1:0];
          end else begin
            r_data <= w_add[OWIDTH-1:0];
          end
        end else begin
          r_data <= w_ext[OWIDTH-1:0];
        end
      end
    end
  end

  assign bus.oValid = r_vld;
  assign bus.oData  = r_data;
  assign bus.oOvf   = r_ovf;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc: wrap, saturate and two-input
// instances driven in lockstep against a delay-line model.
module tb_adder_tree_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic        vld = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] data = '0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adder_tree_acc_if #(.BITWIDTH(8), .NUM_IN(4), .OWIDTH(12)) b4 ();
  adder_tree_acc_if #(.BITWIDTH(8), .NUM_IN(4), .OWIDTH(12)) b4s ();
  adder_tree_acc_if #(.BITWIDTH(8), .NUM_IN(2), .OWIDTH(12)) b2 ();

  assign b4.iEn = en;
  assign b4.iClr = clr;
  assign b4.iValid = vld;
  assign b4.iAccMode = mode;
  assign b4.iData = data;
  assign b4s.iEn = en;
  assign b4s.iClr = clr;
  assign b4s.iValid = vld;
  assign b4s.iAccMode = mode;
  assign b4s.iData = data;
  assign b2.iEn = en;
  assign b2.iClr = clr;
  assign b2.iValid = vld;
  assign b2.iAccMode = mode;
  assign b2.iData = data[15:0];

  adder_tree_acc #(.BITWIDTH(8), .NUM_IN(4), .OWIDTH(12), .ACC_SAT(1'b0))
    dut (.iClk(clk), .iRstN(rst_n), .bus(b4));
  adder_tree_acc #(.BITWIDTH(8), .NUM_IN(4), .OWIDTH(12), .ACC_SAT(1'b1))
    dut_sat (.iClk(clk), .iRstN(rst_n), .bus(b4s));
  adder_tree_acc #(.BITWIDTH(8), .NUM_IN(2), .OWIDTH(12), .ACC_SAT(1'b0))
    dut2 (.iClk(clk), .iRstN(rst_n), .bus(b2));

  // reference: beats travel a delay line, then plain arithmetic
  typedef struct {
    bit v[4];
    int s[4];
    bit m[4];
    int acc;
    bit ovf;
    bit ov;
  } mst_t;

  mst_t m4, m4s, m2;

  function automatic mst_t mzero();
    mst_t r;
    for (int k = 0; k < 4; k++) begin
      r.v[k] = 1'b0;
      r.s[k] = 0;
      r.m[k] = 1'b0;
    end
    r.acc = 0;
    r.ovf = 1'b0;
    r.ov  = 1'b0;
    return r;
  endfunction

  function automatic mst_t mstep(mst_t st, int lv, bit sat, int sum);
    mst_t r;
    int lim;
    int t;
    r = st;
    lim = 1 << 12;
    if (clr) return mzero();
    if (!en) return st;
    r.ov = st.v[lv-1];
    if (st.v[lv-1]) begin
      if (st.m[lv-1]) begin
        t = st.acc + st.s[lv-1];
        if (t >= lim) begin
          r.ovf = 1'b1;
          r.acc = sat ? lim - 1 : t - lim;
        end else begin
          r.acc = t;
        end
      end else begin
        r.acc = st.s[lv-1];
      end
    end
    for (int k = 3; k > 0; k--) begin
      r.v[k] = st.v[k-1];
      r.s[k] = st.s[k-1];
      r.m[k] = st.m[k-1];
    end
    r.v[0] = vld;
    r.s[0] = sum;
    r.m[0] = mode;
    return r;
  endfunction

  function automatic int sum4();
    return int'(data[7:0]) + int'(data[15:8])
         + int'(data[23:16]) + int'(data[31:24]);
  endfunction

  function automatic int sum2();
    return int'(data[7:0]) + int'(data[15:8]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4  <= mzero();
      m4s <= mzero();
      m2  <= mzero();
    end else begin
      m4  <= mstep(m4, 2, 1'b0, sum4());
      m4s <= mstep(m4s, 2, 1'b1, sum4());
      m2  <= mstep(m2, 1, 1'b0, sum2());
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m4.oValid", int'(b4.oValid), int'(m4.ov));
    chk("m4.oData", int'(b4.oData), m4.acc);
    chk("m4.oOvf", int'(b4.oOvf), int'(m4.ovf));
    chk("m4s.oValid", int'(b4s.oValid), int'(m4s.ov));
    chk("m4s.oData", int'(b4s.oData), m4s.acc);
    chk("m4s.oOvf", int'(b4s.oOvf), int'(m4s.ovf));
    chk("m2.oValid", int'(b2.oValid), int'(m2.ov));
    chk("m2.oData", int'(b2.oData), m2.acc);
    chk("m2.oOvf", int'(b2.oOvf), int'(m2.ovf));
  end

  typedef struct {
    logic [7:0] op[4];
    bit         md;
    int         exp_w;
    bit         ovf_w;
    int         exp_s;
    bit         ovf_s;
  } vec_t;

  vec_t tbl[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, b, c, d, input logic md);
    data = {d, c, b, a};
    mode = md;
    vld  = 1'b1;
  endtask

  // single load of {10,20,30,40}: latency and value on both widths
  task automatic single_load(input string nm);
    int lat4;
    int lat2;
    int dat4;
    int dat2;
    lat4 = 0;
    lat2 = 0;
    dat4 = -1;
    dat2 = -1;
    beat(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    step();
    vld = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (b4.oValid && lat4 == 0) begin
        lat4 = c;
        dat4 = int'(b4.oData);
      end
      if (b2.oValid && lat2 == 0) begin
        lat2 = c;
        dat2 = int'(b2.oData);
      end
      step();
    end
    chk({nm, ".lat4"}, lat4, 3);
    chk({nm, ".lat2"}, lat2, 2);
    chk({nm, ".data4"}, dat4, 100);
    chk({nm, ".data2"}, dat2, 30);
    chk({nm, ".hold4"}, int'(b4.oData), 100);
    chk({nm, ".idle4"}, int'(b4.oValid), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{'{8'd10, 8'd20, 8'd30, 8'd40}, 1'b0, 100, 1'b0, 100, 1'b0};
    tbl[1] = '{'{8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[2] = '{'{8'd255, 8'd255, 8'd255, 8'd255}, 1'b1, 1020, 1'b0, 1020, 1'b0};
    tbl[3] = '{'{8'd255, 8'd255, 8'd255, 8'd255}, 1'b1, 2040, 1'b0, 2040, 1'b0};
    tbl[4] = '{'{8'd255, 8'd255, 8'd255, 8'd255}, 1'b1, 3060, 1'b0, 3060, 1'b0};
    tbl[5] = '{'{8'd255, 8'd255, 8'd255, 8'd255}, 1'b1, 4080, 1'b0, 4080, 1'b0};
    tbl[6] = '{'{8'd255, 8'd255, 8'd255, 8'd255}, 1'b1, 1004, 1'b1, 4095, 1'b1};
    tbl[7] = '{'{8'd1, 8'd2, 8'd3, 8'd4}, 1'b0, 10, 1'b1, 10, 1'b1};
    tbl[8] = '{'{8'd255, 8'd255, 8'd255, 8'd255}, 1'b1, 1030, 1'b1, 1030, 1'b1};

    // reset held with a valid beat offered
    beat(8'd7, 8'd7, 8'd7, 8'd7, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rst.oData", int'(b4.oData), 0);
      chk("rst.oValid", int'(b4.oValid), 0);
      chk("rst.oOvf", int'(b4.oOvf), 0);
    end
    vld = 1'b0;
    rst_n = 1'b1;
    step();
    single_load("s1");

    // back-to-back table beats
    for (int i = 0; i < 11; i++) begin
      if (i < 9) begin
        beat(tbl[i].op[0], tbl[i].op[1], tbl[i].op[2], tbl[i].op[3],
             tbl[i].md);
      end else begin
        vld = 1'b0;
      end
      step();
      if (i >= 2) begin
        chk($sformatf("t%0d.vld", i-2), int'(b4.oValid), 1);
        chk($sformatf("t%0d.wrap", i-2), int'(b4.oData), tbl[i-2].exp_w);
        chk($sformatf("t%0d.ovfw", i-2), int'(b4.oOvf), int'(tbl[i-2].ovf_w));
        chk($sformatf("t%0d.sat", i-2), int'(b4s.oData), tbl[i-2].exp_s);
        chk($sformatf("t%0d.ovfs", i-2), int'(b4s.oOvf), int'(tbl[i-2].ovf_s));
      end
    end
    step();

    // stall mid-flight with a beat offered during the stall
    beat(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    step();
    en = 1'b0;
    beat(8'd9, 8'd9, 8'd9, 8'd9, 1'b0);
    for (int c = 2; c <= 6; c++) begin
      step();
      chk("stall.frozen", int'(b4.oData), 1030);
    end
    en = 1'b1;
    vld = 1'b0;
    step();
    chk("stall.c7", int'(b4.oValid), 0);
    step();
    chk("stall.c8vld", int'(b4.oValid), 1);
    chk("stall.c8data", int'(b4.oData), 10);
    en = 1'b0;
    step();
    chk("stall.stretch", int'(b4.oValid), 1);
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("stall.dropped", int'(b4.oValid), 0);
    end

    // clear with beats in flight and one presented
    beat(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    vld = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("clr.novalid", int'(b4.oValid), 0);
      step();
    end
    chk("clr.data", int'(b4.oData), 0);
    chk("clr.ovf", int'(b4.oOvf), 0);
    chk("clr.ovfsat", int'(b4s.oOvf), 0);
    beat(8'd5, 8'd5, 8'd5, 8'd5, 1'b1);
    step();
    vld = 1'b0;
    step();
    step();
    chk("clr.next", int'(b4.oData), 20);

    // async reset between edges while accumulating
    beat(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    for (int c = 0; c < 4; c++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.data", int'(b4.oData), 0);
    chk("arst.valid", int'(b4.oValid), 0);
    chk("arst.sat", int'(b4s.oData), 0);
    chk("arst.data2", int'(b2.oData), 0);
    vld = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    single_load("s6");

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      en   = ($urandom % 8) != 0;
      clr  = ($urandom % 50) == 0;
      vld  = ($urandom % 3) != 0;
      mode = ($urandom % 4) != 0;
      for (int k = 0; k < 4; k++) begin
        data[k*8 +: 8] = ($urandom % 2) != 0 ?
          8'(200 + $urandom % 56) : 8'($urandom);
      end
      step();
    end
    en = 1'b1;
    clr = 1'b0;
    vld = 1'b0;
    for (int c = 0; c < 5; c++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
